// File: rtl/mips_pkg.sv
// Shared pipeline constants for the 5-stage MIPS core: Tnew/Tuse timing codes
// and the operand forward-source encodings.
package mips_pkg;

    localparam int unsigned TW = 2;
    localparam int unsigned AW = 5;

    localparam logic [TW-1:0] T_D = TW'(0);
    localparam logic [TW-1:0] T_E = TW'(1);
    localparam logic [TW-1:0] T_M = TW'(2);

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks the youngest in-flight writer of a single
// architectural register from E through W.
module sb_entry #(
    parameter int unsigned TW = mips_pkg::TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alloc,
    input  logic [TW-1:0] i_tnew,
    output logic          o_pend,
    output logic [1:0]    o_age,
    output logic [TW-1:0] o_tnew
);

    logic          r_pend;
    logic [1:0]    r_age;
    logic [TW-1:0] r_tnew;

    // Allocation beats advance/retire so an older writer leaving W cannot clear a newer one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_age  <= 2'd0;
            r_tnew <= '0;
        end else if (i_alloc) begin
            r_pend <= 1'b1;
            r_age  <= 2'd0;
            r_tnew <= i_tnew;
        end else if (r_pend) begin
            if (r_age == 2'd2) begin
                r_pend <= 1'b0;
                r_age  <= 2'd0;
                r_tnew <= '0;
            end else begin
                r_age  <= 2'(r_age + 2'd1);
                r_tnew <= (r_tnew == '0) ? '0 : TW'(r_tnew - TW'(1));
            end
        end
    end

    assign o_pend = r_pend;
    assign o_age  = r_age;
    assign o_tnew = r_tnew;

endmodule

// File: rtl/grf_scoreboard.sv
// Register hazard scoreboard: per-register youngest-writer tracking, D-stage
// stall request and forward-source select for the rs/rt read ports.
module grf_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned TW   = mips_pkg::TW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [mips_pkg::AW-1:0] rs_addr,
    input  logic [mips_pkg::AW-1:0] rt_addr,
    input  logic                    rs_ren,
    input  logic                    rt_ren,
    input  logic [TW-1:0]           rs_tuse,
    input  logic [TW-1:0]           rt_tuse,
    input  logic [mips_pkg::AW-1:0] dst_addr,
    input  logic                    dst_wen,
    input  logic [TW-1:0]           dst_tnew,
    output logic                    stall,
    output logic [1:0]              rs_fwd,
    output logic [1:0]              rt_fwd
);

    localparam int unsigned AW = mips_pkg::AW;

    logic [NREG-1:0]         w_pend;
    logic [NREG-1:0][1:0]    w_age;
    logic [NREG-1:0][TW-1:0] w_tnew;
    logic [NREG-1:0]         w_alloc;
    logic                    w_hz_rs;
    logic                    w_hz_rt;
    logic                    w_alloc_any;

    // Register 0 is hard-wired zero and never has a writer.
    assign w_pend[0]  = 1'b0;
    assign w_age[0]   = 2'd0;
    assign w_tnew[0]  = '0;
    assign w_alloc[0] = 1'b0;

    assign w_alloc_any = issue_valid && !stall && dst_wen && (dst_addr != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        assign w_alloc[r] = w_alloc_any && (dst_addr == AW'(r));

        sb_entry #(.TW(TW)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .i_alloc (w_alloc[r]),
            .i_tnew  (dst_tnew),
            .o_pend  (w_pend[r]),
            .o_age   (w_age[r]),
            .o_tnew  (w_tnew[r])
        );
    end

    always_comb begin
        w_hz_rs = 1'b0;
        w_hz_rt = 1'b0;
        rs_fwd  = mips_pkg::FWD_GRF;
        rt_fwd  = mips_pkg::FWD_GRF;
        if (rs_ren && (rs_addr != '0) && w_pend[rs_addr]) begin
            w_hz_rs = issue_valid && (w_tnew[rs_addr] > rs_tuse);
            rs_fwd  = 2'(w_age[rs_addr] + 2'd1);
        end
        if (rt_ren && (rt_addr != '0) && w_pend[rt_addr]) begin
            w_hz_rt = issue_valid && (w_tnew[rt_addr] > rt_tuse);
            rt_fwd  = 2'(w_age[rt_addr] + 2'd1);
        end
        stall = w_hz_rs || w_hz_rt;
    end

endmodule
